cdr_deserializer: RTL and testbench

CDR_DESERIALIZER -- requirements
Module: cdr_deserializer

---
 rtl/cdr_deserializer.sv | 154 +++++++++++++++
 tb/tb_cdr_deserializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_deserializer.sv
// Serial-to-parallel deserializer for a recovered CDR bit stream. It hunts for a
// sync word, tracks frame alignment and emits data words with a start-of-frame flag.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | CDR not locked, or one edge after lock rises; data_in ignored
// ST_HUNT    | shifting bits in and searching for SYNC_WORD
// ST_LOCKED  | frame aligned; data words emitted, sync slot checked
module cdr_deserializer #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hBC,
    parameter int               FRAME_WORDS = 4,
    parameter int               MISS_LIMIT  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lock,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             sof,
    output logic             aligned,
    output logic             sync_err
);

    localparam int FCW = $clog2(WIDTH + 1);
    localparam int BCW = $clog2(WIDTH);
    localparam int WIW = $clog2(FRAME_WORDS + 1);
    localparam int MCW = $clog2(MISS_LIMIT + 1);

    localparam logic [FCW-1:0] FILL_FULL = FCW'(WIDTH);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
    localparam logic [WIW-1:0] IDX_SYNC  = WIW'(FRAME_WORDS);
    localparam logic [MCW-1:0] MISS_MAX  = MCW'(MISS_LIMIT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]       r_state;
    // Only the low WIDTH-1 bits of history are needed; the incoming bit completes the word.
    logic [WIDTH-2:0] r_sr;
    logic [FCW-1:0]   r_fill;
    logic [BCW-1:0]   r_bitcnt;
    logic [WIW-1:0]   r_widx;
    logic [MCW-1:0]   r_miss;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_sof;
    logic             r_aligned;
    logic             r_sync_err;

    logic [WIDTH-1:0] w_nsr;
    logic [FCW-1:0]   w_fill_nxt;
    logic [MCW-1:0]   w_miss_inc;
    logic             w_sync_ok;
    logic             w_word_done;
    logic             w_hunt_hit;
    logic             w_sync_slot;
    logic             w_drop;
    logic [1:0]       w_state_nxt;

    assign w_nsr       = {r_sr, data_in};
    assign w_fill_nxt  = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
    assign w_miss_inc  = r_miss + 1'b1;
    assign w_sync_ok   = (w_nsr == SYNC_WORD);
    assign w_word_done = (r_bitcnt == BIT_LAST);
    assign w_hunt_hit  = (r_state == ST_HUNT) && (w_fill_nxt == FILL_FULL) && w_sync_ok;
    assign w_sync_slot = (r_state == ST_LOCKED) && w_word_done && (r_widx == IDX_SYNC);
    assign w_drop      = w_sync_slot && !w_sync_ok && (w_miss_inc == MISS_MAX);

    always_comb begin
        w_state_nxt = r_state;
        if (!lock) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_HUNT;
                ST_HUNT:   w_state_nxt = w_hunt_hit ? ST_LOCKED : ST_HUNT;
                ST_LOCKED: w_state_nxt = w_drop ? ST_HUNT : ST_LOCKED;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sr         <= '0;
            r_fill       <= '0;
            r_bitcnt     <= '0;
            r_widx       <= '0;
            r_miss       <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_aligned    <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_aligned    <= (w_state_nxt == ST_LOCKED);
            r_data_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_sync_err   <= 1'b0;
            if (!lock) begin
                r_sr     <= '0;
                r_fill   <= '0;
                r_bitcnt <= '0;
                r_widx   <= '0;
                r_miss   <= '0;
            end else if (r_state == ST_HUNT) begin
                r_sr   <= w_nsr[WIDTH-2:0];
                r_fill <= w_fill_nxt;
                if (w_hunt_hit) begin
                    r_bitcnt <= '0;
                    r_widx   <= '0;
                    r_miss   <= '0;
                end
            end else if (r_state == ST_LOCKED) begin
                r_sr <= w_nsr[WIDTH-2:0];
                if (!w_word_done) begin
                    r_bitcnt <= r_bitcnt + 1'b1;
                end else begin
                    r_bitcnt <= '0;
                    if (w_sync_slot) begin
                        r_widx <= '0;
                        if (w_sync_ok) begin
                            r_miss <= '0;
                        end else begin
                            r_sync_err <= 1'b1;
                            r_miss     <= w_miss_inc;
                        end
                        // Losing alignment restarts the fill so a fresh full word is needed.
                        if (w_drop) begin
                            r_fill <= '0;
                        end
                    end else begin
                        r_data_out   <= w_nsr;
                        r_data_valid <= 1'b1;
                        r_sof        <= (r_widx == '0);
                        r_widx       <= r_widx + 1'b1;
                    end
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign sof        = r_sof;
    assign aligned    = r_aligned;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_cdr_deserializer.sv
// Bench for cdr_deserializer: directed frame scenarios plus a randomized stream,
// all outputs compared every cycle against a bit-history reference model.
module tb_cdr_deserializer;

    localparam int         W    = 8;
    localparam logic [7:0] SYNC = 8'hBC;
    localparam int         FW   = 4;
    localparam int         LIM  = 3;

    logic         clk;
    logic         rst_n;
    logic         lock;
    logic         data_in;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         sof;
    logic         aligned;
    logic         sync_err;

    int n_tests;
    int n_fail;
    int cnt_dv;
    int cnt_sof;
    int cnt_serr;

    // reference model: mode 0 = idle, 1 = hunting, 2 = aligned
    int         m_mode;
    int         m_pos;
    int         m_miss;
    bit         m_hist[$];
    logic [7:0] m_data;
    logic       e_dv;
    logic       e_sof;
    logic       e_serr;

    cdr_deserializer #(
        .WIDTH(W), .SYNC_WORD(SYNC), .FRAME_WORDS(FW), .MISS_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lock(lock), .data_in(data_in),
        .data_out(data_out), .data_valid(data_valid), .sof(sof),
        .aligned(aligned), .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pos  = 0;
        m_miss = 0;
        m_hist.delete();
        m_data = '0;
        e_dv   = 1'b0;
        e_sof  = 1'b0;
        e_serr = 1'b0;
    endtask

    task automatic model_step(input logic lk, input logic b);
        logic [7:0] win;
        int k;
        e_dv = 1'b0; e_sof = 1'b0; e_serr = 1'b0;
        if (!lk) begin
            m_mode = 0;
            m_hist.delete();
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_hist.delete();
        end else begin
            m_hist.push_back(b);
            if (m_hist.size() > W) m_hist.delete(0);
            win = '0;
            foreach (m_hist[i]) win = {win[W-2:0], m_hist[i]};
            if (m_mode == 1) begin
                if (m_hist.size() == W && win == SYNC) begin
                    m_mode = 2; m_pos = 0; m_miss = 0;
                end
            end else begin
                m_pos++;
                if (m_pos % W == 0) begin
                    k = ((m_pos / W) - 1) % (FW + 1);
                    if (k < FW) begin
                        e_dv = 1'b1; e_sof = (k == 0); m_data = win;
                    end else if (win != SYNC) begin
                        e_serr = 1'b1;
                        m_miss++;
                        if (m_miss >= LIM) begin
                            m_mode = 1;
                            m_hist.delete();
                        end
                    end else begin
                        m_miss = 0;
                    end
                end
            end
        end
    endtask

    task automatic send_bit(input logic lk, input logic b);
        lock = lk;
        data_in = b;
        @(posedge clk);
        #1;
        model_step(lk, b);
        check_val("data_valid", 32'(data_valid), 32'(e_dv));
        check_val("sof", 32'(sof), 32'(e_sof));
        check_val("sync_err", 32'(sync_err), 32'(e_serr));
        check_val("aligned", 32'(aligned), 32'(m_mode == 2));
        check_val("data_out", 32'(data_out), 32'(m_data));
        cnt_dv   += int'(data_valid);
        cnt_sof  += int'(sof);
        cnt_serr += int'(sync_err);
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(1'b1, w[i]);
    endtask

    task automatic push_word_rand_lock(input logic [7:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit($urandom_range(0, 249) != 0, w[i]);
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input logic [7:0] s);
        push_word(a); push_word(b); push_word(c); push_word(d); push_word(s);
    endtask

    task automatic clear_counts();
        cnt_dv = 0; cnt_sof = 0; cnt_serr = 0;
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] partial;
        n_tests = 0;
        n_fail  = 0;
        clear_counts();
        rst_n   = 1'b0;
        lock    = 1'b0;
        data_in = 1'b0;
        model_reset();

        #12;
        check_val("rst_data_out", 32'(data_out), 32'h0);
        check_val("rst_valid", 32'(data_valid), 32'h0);
        check_val("rst_aligned", 32'(aligned), 32'h0);
        check_val("rst_sof_serr", 32'({sof, sync_err}), 32'h0);
        rst_n = 1'b1;

        // Basic acquisition: idle edge, 3 junk bits, sync, one frame, sync
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        push_word(SYNC);
        check_val("acq_aligned", 32'(aligned), 32'h1);
        clear_counts();
        push_frame(8'h11, 8'h22, 8'h33, 8'h44, SYNC);
        check_val("acq_dv_cnt", 32'(cnt_dv), 32'd4);
        check_val("acq_sof_cnt", 32'(cnt_sof), 32'd1);
        check_val("acq_serr_cnt", 32'(cnt_serr), 32'd0);
        check_val("acq_last_data", 32'(data_out), 32'h44);

        // Two bad sync slots then a good one: stays aligned, miss count cleared
        clear_counts();
        push_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'hBD);
        push_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'hBD);
        push_frame(8'h09, 8'h0A, 8'h0B, 8'h0C, SYNC);
        check_val("miss2_serr_cnt", 32'(cnt_serr), 32'd2);
        check_val("miss2_aligned", 32'(aligned), 32'h1);
        push_frame(8'h0D, 8'h0E, 8'h0F, 8'h10, 8'hBD);
        push_frame(8'h12, 8'h13, 8'h14, 8'h15, 8'hBD);
        check_val("miss_cleared_aligned", 32'(aligned), 32'h1);
        push_frame(8'h16, 8'h17, 8'h18, 8'h19, SYNC);

        // Three bad sync slots: the third drops alignment on its error pulse
        clear_counts();
        push_frame(8'h21, 8'h23, 8'h24, 8'h25, 8'hBD);
        push_frame(8'h26, 8'h27, 8'h28, 8'h29, 8'hBD);
        push_frame(8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'hBE);
        check_val("drop_serr", 32'(sync_err), 32'h1);
        check_val("drop_aligned", 32'(aligned), 32'h0);
        check_val("drop_serr_cnt", 32'(cnt_serr), 32'd3);

        // Partial fill that matches the sync word's low bits must not align
        partial = 8'h3C;
        for (int i = 5; i >= 0; i--) send_bit(1'b1, partial[i]);
        check_val("partial_no_align", 32'(aligned), 32'h0);
        push_word(SYNC);
        check_val("relock_aligned", 32'(aligned), 32'h1);
        push_frame(8'h55, 8'h66, 8'h77, 8'h88, SYNC);

        // Lock drop mid-word, then re-hunt before any data
        w = 8'hA5;
        for (int i = 7; i >= 5; i--) send_bit(1'b1, w[i]);
        send_bit(1'b0, 1'b1);
        check_val("lkdrop_aligned", 32'(aligned), 32'h0);
        check_val("lkdrop_hold", 32'(data_out), 32'h88);
        clear_counts();
        send_bit(1'b1, 1'b0);
        push_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
        check_val("rehunt_no_dv", 32'(cnt_dv), 32'd0);
        push_word(SYNC);
        push_frame(8'h9A, 8'h9B, 8'h9C, 8'h9D, SYNC);

        // Asynchronous reset right after a data strobe
        push_word(8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_data_out", 32'(data_out), 32'h0);
        check_val("arst_valid", 32'(data_valid), 32'h0);
        check_val("arst_sof", 32'(sof), 32'h0);
        check_val("arst_aligned", 32'(aligned), 32'h0);
        model_reset();
        #3;
        rst_n = 1'b1;

        // Randomized stream: junk bits, random data, occasional bad syncs and lock drops
        send_bit(1'b1, 1'b0);
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 5)); j++)
                    send_bit(1'b1, 1'($urandom_range(0, 1)));
            end
            for (int j = 0; j < FW; j++) push_word_rand_lock(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 5) == 0) push_word_rand_lock(8'($urandom_range(0, 255)));
            else push_word_rand_lock(SYNC);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
